// File: rtl/pc_unit.sv
// pc_unit: next-PC generation with branch/jump/register-jump priority, instruction counter,
// and an optional return-address stack checker enabled by defining PC_UNIT_RAS_EN.
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [15:0]       br_off_i,
  input  logic              j_i,
  input  logic              jal_i,
  input  logic [25:0]       j_idx_i,
  input  logic              jr_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic              link_we_o,
  output logic [ADDR_W-1:0] link_o,
  output logic              misalign_o,
  output logic [31:0]       icount_o,
  output logic [4:0]        ras_depth_o,
  output logic              ras_err_o
);
  logic [ADDR_W-1:0] pc_q, pc_d, j_tgt, jr_tgt, br_tgt;
  logic [31:0]       icount_q, icount_d;
  logic              misalign_q, misalign_d;
  logic              go;
  assign go     = ~stall_i;
  assign pc4_o  = pc_q + ADDR_W'(4);
  assign jr_tgt = {jr_addr_i[ADDR_W-1:2], 2'b00};
  assign br_tgt = pc4_o + {{(ADDR_W-18){br_off_i[15]}}, br_off_i, 2'b00};
  // Jump keeps the upper region bits of pc+4; works down to ADDR_W=28.
  always_comb begin
    j_tgt       = pc4_o;
    j_tgt[27:0] = {j_idx_i, 2'b00};
  end
  always_comb begin
    pc_d       = !go ? pc_q : jr_i ? jr_tgt : (j_i | jal_i) ? j_tgt : br_taken_i ? br_tgt : pc4_o;
    icount_d   = go ? icount_q + 32'd1 : icount_q;
    misalign_d = go & jr_i & (|jr_addr_i[1:0]);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q       <= RESET_PC;
      icount_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      icount_q   <= icount_d;
      misalign_q <= misalign_d;
    end
  end
  assign pc_o       = pc_q;
  assign icount_o   = icount_q;
  assign misalign_o = misalign_q;
  assign link_o     = pc4_o;
  assign link_we_o  = jal_i & go;
`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d, top_idx;
  logic [4:0]        depth_q, depth_d;
  logic              err_q, err_d;
  logic              push, pop;
  assign push    = go & jal_i & ~jr_i;
  assign pop     = go & jr_i & ret_i;
  assign top_idx = ptr_q - PW'(1);
  // Circular buffer: a push when full overwrites the oldest entry.
  always_comb begin
    ras_d   = ras_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    err_d   = 1'b0;
    if (push) begin
      ras_d[ptr_q] = pc4_o;
      ptr_d        = ptr_q + PW'(1);
      depth_d      = (depth_q == 5'(RAS_DEPTH)) ? depth_q : depth_q + 5'd1;
    end else if (pop) begin
      err_d   = (depth_q == 5'd0) || (ras_q[top_idx] != jr_tgt);
      ptr_d   = (depth_q == 5'd0) ? ptr_q : top_idx;
      depth_d = (depth_q == 5'd0) ? depth_q : depth_q - 5'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ras_q   <= ras_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end
  assign ras_depth_o = depth_q;
  assign ras_err_o   = err_q;
`else
  logic unused_ret;
  assign unused_ret  = ret_i;
  assign ras_depth_o = '0;
  assign ras_err_o   = 1'b0;
`endif
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC/address width in bits; legal range 28..64.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset; bits [1:0] are 0.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; legal range 2..16, power of two.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  synchronous active-low reset.
REQ-007 stall_i  in  1  hold all state this cycle.
REQ-008 br_taken_i  in  1  conditional branch resolved taken.
REQ-009 br_off_i  in  16  branch word offset, signed.
REQ-010 j_i  in  1  absolute jump (j).
REQ-011 jal_i  in  1  jump and link.
REQ-012 j_idx_i  in  26  jump word index.
REQ-013 jr_i  in  1  register jump.
REQ-014 ret_i  in  1  register jump that is a return (jr $31); qualifies jr_i.
REQ-015 jr_addr_i  in  ADDR_W  register jump target.
REQ-016 pc_o  out  ADDR_W  current PC, registered.
REQ-017 pc4_o  out  ADDR_W  pc_o+4, combinational.
REQ-018 link_we_o  out  1  jal_i & ~stall_i; link_o is to be written to $31.
REQ-019 link_o  out  ADDR_W  equals pc4_o.
REQ-020 misalign_o  out  1  registered; pulses 1 cycle after a jr target with bits [1:0] != 0.
REQ-021 icount_o  out  32  registered count of non-stalled cycles.
REQ-022 ras_depth_o  out  5  registered RAS occupancy.
REQ-023 ras_err_o  out  1  registered; pulses on a return mismatch or a return with the RAS empty.

Function
REQ-024 Next PC SHALL follow this priority: jr_i -> {jr_addr_i[ADDR_W-1:2],2'b00}; else j_i|jal_i -> {pc4_o[ADDR_W-1:28], j_idx_i, 2'b00}; else br_taken_i -> pc4_o + (sext(br_off_i)<<2); else pc4_o.
REQ-025 All address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-026 pc_o SHALL load the next PC at the rising edge after the control inputs are presented (latency 1); control inputs are combinational from the current instruction.
REQ-027 stall_i=1 SHALL hold pc_o, icount_o and the RAS, and force link_we_o=0; misalign_o and ras_err_o SHALL be 0 the next cycle.
REQ-028 icount_o SHALL increment by 1 on each non-stalled cycle and wrap from 0xFFFFFFFF to 0.
REQ-029 misalign_o SHALL be 1 for exactly the cycle after a non-stalled jr_i with jr_addr_i[1:0] != 0.
REQ-030 RAS push: a non-stalled jal_i without jr_i SHALL push pc4_o.
REQ-031 RAS push when full SHALL overwrite the oldest entry (circular); ras_depth_o saturates at RAS_DEPTH.
REQ-032 RAS pop: a non-stalled jr_i&ret_i SHALL pop. ras_err_o=1 the next cycle if top != the aligned target or the RAS is empty; an empty pop leaves ras_depth_o at 0.
REQ-033 jr_i&ret_i together with jal_i SHALL pop only; jal_i is ignored for next PC and for the push, but link_we_o still follows REQ-018.
REQ-034 The RAS SHALL only check; it never alters the next PC.

Reset
REQ-035 rst_i=0 at a rising edge SHALL set pc_o=RESET_PC, icount_o=0, ras_depth_o=0, misalign_o=0, ras_err_o=0 and empty the RAS; reset overrides stall_i and all controls.
REQ-036 Reset asserted mid-operation SHALL discard pending control and restart at RESET_PC on the first edge with rst_i=1.

Configuration
REQ-037 Macro PC_UNIT_RAS_EN defined: RAS per REQ-030..REQ-034.
REQ-038 Macro PC_UNIT_RAS_EN undefined: no RAS storage; ras_depth_o=0 and ras_err_o=0 constantly; ret_i ignored; all other behaviour identical.

Verification
REQ-039 Reset then 3 idle cycles -> pc_o 0,4,8,12; icount_o 0,1,2,3.
REQ-040 pc_o=0x100, br_taken_i=1, br_off_i=0xFFFF -> pc_o=0x100; br_off_i=0x0003 from 0x100 -> 0x110.
REQ-041 pc_o=0x00400010, jal_i=1, j_idx_i=0x0000040 -> link_we_o=1, link_o=0x00400014, pc_o=0x00000100, ras_depth_o=1; then jr_i=ret_i=1, jr_addr_i=0x00400014 -> pc_o=0x00400014, ras_err_o=0.
REQ-042 With RAS_DEPTH=4: 5 jals, then 5 returns with correct targets -> ras_depth_o stays 4, first 4 returns ras_err_o=0, 5th ras_err_o=1.
REQ-043 jr_i=1, jr_addr_i=0x203 -> pc_o=0x200, misalign_o=1 for one cycle; same stimulus with stall_i=1 -> no PC change and misalign_o=0.
REQ-044 rst_i=0 asserted during a stalled jal -> pc_o=RESET_PC, ras_depth_o=0, icount_o=0.
